// File: rtl/gte_mon_pkg.sv
// gte_mon_pkg
//   Shared definitions for the comparator debounce monitor:
//   - state_t : 2-bit debounce FSM encoding (LOW=00, LOW_PEND=01,
//               HIGH=10, HIGH_PEND=11). Bit 1 is the debounced level.
//   - default DEB_LEN / CNT_W / TIMEOUT_CYC values
//   - clog2 : constant-evaluable ceiling log2 for sizing counters
package gte_mon_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    LOW_PEND  = 2'b01,
    HIGH      = 2'b10,
    HIGH_PEND = 2'b11
  } state_t;

  localparam int DEB_LEN_DEF     = 4;
  localparam int CNT_W_DEF       = 8;
  localparam int TIMEOUT_CYC_DEF = 16;

  // Smallest r with 2**r >= n (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/gte_sat_counter.sv
// gte_sat_counter
//   Saturating up-counter with a synchronous clear.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (cnt -> 0)
//     clr   : synchronous clear; a coincident inc is still counted (cnt -> 1)
//     inc   : count one event this cycle
//     cnt   : current count, stops at MAX
//     sat   : cnt == MAX
//   MAX defaults to all-ones so the counter saturates without wrapping.
module gte_sat_counter #(
  parameter int W   = 8,
  parameter int MAX = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign sat = (cnt == MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      // Clear first, then the event of this same cycle is counted.
      cnt <= inc ? W'(1) : '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gte_debounce_monitor.sv
// gte_debounce_monitor
//   Debounces the single-bit result of the 6-bit >= comparator, emits
//   rise/fall pulses and keeps a saturating count of rising events.
//   Optional feature macro: GTE_MON_TIMEOUT_EN (idle timeout / stale flag).
//
//   Ports:
//     clk        : rising-edge clock
//     reset_n    : asynchronous active-low reset
//     clr        : synchronous clear of rise_cnt / cnt_sat (FSM untouched)
//     gte_valid  : gte_in carries a fresh sample this cycle
//     gte_in     : comparator result (1 = a >= b)
//     ge_state   : debounced comparator state (registered)
//     rise_pulse : one cycle, ge_state 0->1
//     fall_pulse : one cycle, ge_state 1->0
//     rise_cnt   : saturating count of rising events
//     cnt_sat    : rise_cnt is all-ones
//     stale      : no gte_valid for TIMEOUT_CYC cycles (0 when compiled out)
//     dbg_state  : current debounce FSM state
//
//   Handshake: gte_valid is a pure qualifier with no ready; every cycle
//   with gte_valid=1 is consumed as exactly one sample, cycles with
//   gte_valid=0 leave the FSM and run count untouched.
module gte_debounce_monitor
  import gte_mon_pkg::*;
#(
  parameter int DEB_LEN     = DEB_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             gte_valid,
  input  logic             gte_in,
  output logic             ge_state,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             cnt_sat,
  output logic             stale,
  output state_t           dbg_state
);

  localparam int               RUN_W    = clog2(DEB_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_LEN);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic             rise_d, fall_d;
  logic             timeout_hit;

`ifdef GTE_MON_TIMEOUT_EN
  localparam int IDLE_W = clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Counts idle cycles up to TIMEOUT_CYC and parks there; sat is the flag.
  gte_sat_counter #(.W(IDLE_W), .MAX(TIMEOUT_CYC)) u_idle (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (gte_valid),
    .inc   (!gte_valid),
    .cnt   (idle_cnt),
    .sat   (stale)
  );

  // Fire on the edge that moves the idle count onto TIMEOUT_CYC so the
  // PEND fallback becomes visible together with stale.
  assign timeout_hit = !gte_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
`else
  assign stale       = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    run_inc = run_q + RUN_W'(1);
    if (timeout_hit && (state_q == LOW_PEND || state_q == HIGH_PEND)) begin
      state_d = (state_q == LOW_PEND) ? LOW : HIGH;
      run_d   = '0;
    end else if (gte_valid) begin
      case (state_q)
        LOW, LOW_PEND: begin
          if (gte_in) begin
            if (run_inc == RUN_LAST) begin
              state_d = HIGH;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = LOW_PEND;
              run_d   = run_inc;
            end
          end else begin
            state_d = LOW;
            run_d   = '0;
          end
        end
        HIGH, HIGH_PEND: begin
          if (!gte_in) begin
            if (run_inc == RUN_LAST) begin
              state_d = LOW;
              run_d   = '0;
              fall_d  = 1'b1;
            end else begin
              state_d = HIGH_PEND;
              run_d   = run_inc;
            end
          end else begin
            state_d = HIGH;
            run_d   = '0;
          end
        end
        default: begin
          state_d = LOW;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LOW;
      run_q      <= '0;
      ge_state   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      ge_state   <= state_d[1];
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  assign dbg_state = state_q;

  // Counts on the same edge that registers rise_pulse, so rise_cnt and the
  // pulse update together.
  gte_sat_counter #(.W(CNT_W)) u_rise (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (clr),
    .inc   (rise_d),
    .cnt   (rise_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_gte_debounce_monitor.sv
// tb_gte_debounce_monitor
//   Two instances share one stimulus stream: CNT_W=8 and CNT_W=2 (the
//   latter exercises saturation). Expected outputs per clock are pushed
//   to exp_q by the driver and popped by an independent monitor.
module tb_gte_debounce_monitor;
  import gte_mon_pkg::*;

  localparam int DEB = 4;
  localparam int TO  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr = 1'b0;
  logic gte_valid = 1'b0;
  logic gte_in = 1'b0;

  always #5 clk = ~clk;

  logic       ge8, rise8, fall8, sat8, stale8;
  logic [7:0] cnt8;
  state_t     st8;
  logic       ge2, rise2, fall2, sat2, stale2;
  logic [1:0] cnt2;
  state_t     st2;

  gte_debounce_monitor #(.DEB_LEN(DEB), .CNT_W(8), .TIMEOUT_CYC(TO)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .gte_valid(gte_valid), .gte_in(gte_in),
    .ge_state(ge8), .rise_pulse(rise8), .fall_pulse(fall8), .rise_cnt(cnt8),
    .cnt_sat(sat8), .stale(stale8), .dbg_state(st8)
  );

  gte_debounce_monitor #(.DEB_LEN(DEB), .CNT_W(2), .TIMEOUT_CYC(TO)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .gte_valid(gte_valid), .gte_in(gte_in),
    .ge_state(ge2), .rise_pulse(rise2), .fall_pulse(fall2), .rise_cnt(cnt2),
    .cnt_sat(sat2), .stale(stale2), .dbg_state(st2)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] st;
    logic       ge;
    logic       rise;
    logic       fall;
    logic [7:0] c8;
    logic       s8;
    logic [1:0] c2;
    logic       s2;
    logic       stale;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int m_level = 0;   // debounced level
  int m_run   = 0;   // consecutive valid samples disagreeing with m_level
  int m_idle  = 0;   // cycles since last valid sample (capped at TO)
  int m_rises = 0;   // rises since last clr (capped well above 255)

  task automatic model_step();
    exp_t e;
    int   rise, fall;
    rise = 0;
    fall = 0;
    if (!reset_n) begin
      m_level = 0; m_run = 0; m_idle = 0; m_rises = 0;
    end else begin
      if (gte_valid) begin
        m_idle = 0;
        if (int'(gte_in) != m_level) begin
          m_run = m_run + 1;
          if (m_run == DEB) begin
            m_level = int'(gte_in);
            m_run   = 0;
            rise    = m_level;
            fall    = 1 - m_level;
          end
        end else begin
          m_run = 0;
        end
      end else begin
`ifdef GTE_MON_TIMEOUT_EN
        if (m_idle < TO) begin
          m_idle = m_idle + 1;
          if (m_idle == TO) m_run = 0;
        end
`endif
      end
      if (clr) m_rises = rise;
      else if (rise != 0 && m_rises < 1000) m_rises = m_rises + 1;
    end
    e.st    = 2'(m_level * 2 + ((m_run > 0) ? 1 : 0));
    e.ge    = (m_level != 0);
    e.rise  = (rise != 0);
    e.fall  = (fall != 0);
    e.c8    = 8'((m_rises > 255) ? 255 : m_rises);
    e.s8    = (m_rises >= 255);
    e.c2    = 2'((m_rises > 3) ? 3 : m_rises);
    e.s2    = (m_rises >= 3);
    e.stale = (m_idle == TO);
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic d, input logic c);
    @(negedge clk);
    reset_n   = r;
    gte_valid = v;
    gte_in    = d;
    clr       = c;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic samples(input logic d, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, d, 1'b0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dbg_state8", 32'(st8), 32'(e.st));
      chk("dbg_state2", 32'(st2), 32'(e.st));
      chk("ge_state",   32'(ge8), 32'(e.ge));
      chk("rise_pulse", 32'(rise8), 32'(e.rise));
      chk("fall_pulse", 32'(fall8), 32'(e.fall));
      chk("rise_cnt8",  32'(cnt8), 32'(e.c8));
      chk("cnt_sat8",   32'(sat8), 32'(e.s8));
      chk("rise_cnt2",  32'(cnt2), 32'(e.c2));
      chk("cnt_sat2",   32'(sat2), 32'(e.s2));
      chk("stale8",     32'(stale8), 32'(e.stale));
      chk("stale2",     32'(stale2), 32'(e.stale));
      chk("pulse_excl", 32'(rise8 & fall8), 32'(0));
      chk("dut2_level", 32'({ge2, rise2, fall2}), 32'({e.ge, e.rise, e.fall}));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lvl;
    // 1. reset held with active inputs, then a clean rise
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    samples(1'b1, 4);
    idle(2);
    samples(1'b0, 4);                        // back to LOW
    // 2. glitch rejection
    samples(1'b1, 3); samples(1'b0, 1); samples(1'b1, 3);
    idle(1);
    samples(1'b1, 1);
    // 4. fall path
    samples(1'b0, 4);
    // 3. gapped valids
    for (int i = 0; i < 4; i++) begin
      samples(1'b1, 1);
      idle(3);
    end
    samples(1'b0, 4);
    // 5. saturation, then clr coincident with a rise
    for (int i = 0; i < 5; i++) begin
      samples(1'b1, 4);
      samples(1'b0, 4);
    end
    samples(1'b1, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    samples(1'b0, 4);
    step(1'b1, 1'b0, 1'b0, 1'b1);            // plain clr
    // reset mid-debounce discards the partial run
    samples(1'b1, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    samples(1'b1, 2);
    samples(1'b1, 2);
    samples(1'b0, 4);
    // 6. idle timeout from LOW_PEND and from HIGH_PEND
    samples(1'b1, 2);
    idle(TO);
    samples(1'b1, 1);
    samples(1'b1, 3);
    samples(1'b0, 2);
    idle(TO + 2);
    samples(1'b0, 4);
    // randomized traffic
    lvl = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        idle($urandom_range(TO - 2, TO + 3));
      end else if ($urandom_range(0, 199) == 0) begin
        step(1'b0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0);
      end else begin
        if ($urandom_range(0, 9) < 3) lvl = 1 - lvl;
        step(1'b1, ($urandom_range(0, 9) < 6), 1'(lvl), ($urandom_range(0, 39) == 0));
      end
    end
    idle(2);
    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
